// File: rtl/multicycle_divider_pkg.sv
// multicycle_divider_pkg: shared divider state encodings and default operand width
package multicycle_divider_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } div_state_t;

endpackage

// File: rtl/multicycle_divider_div_step.sv
// div_step: one restoring shift-subtract step; dividend bits shift out of num as quotient bits shift in
module div_step
    import multicycle_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] num_in,
    input  logic [WIDTH-1:0] den,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] num_out
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // a borrow out of the trial subtraction means the divisor did not fit: restore
    always_comb begin
        trial   = {rem_in, num_in[WIDTH-1]};
        diff    = trial - {1'b0, den};
        rem_out = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        num_out = {num_in[WIDTH-2:0], ~diff[WIDTH]};
    end

endmodule

// File: rtl/multicycle_divider.sv
// multicycle_divider: WIDTH-cycle restoring divider (hi=remainder, lo=quotient); MULTICYCLE_DIVIDER_SIGNED_EN enables DIV
module multicycle_divider
    import multicycle_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t     state;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] num_nx;
    logic [WIDTH-1:0] rem_nx;
    logic a_neg, b_neg, q_neg, r_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in (rem),
        .num_in (num),
        .den    (den),
        .rem_out(rem_nx),
        .num_out(num_nx)
    );

`ifdef MULTICYCLE_DIVIDER_SIGNED_EN
    logic sgn;
    logic sq, sr;
    assign a_neg = sgn & num[WIDTH-1];
    assign b_neg = sgn & den[WIDTH-1];
    assign q_neg = sq;
    assign r_neg = sr;
    // latch the mode with the operands, then record result signs while operands are still raw
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sgn <= 1'b0;
            sq  <= 1'b0;
            sr  <= 1'b0;
        end else if (!cancel && start && (state == S_IDLE || state == S_DONE)) begin
            sgn <= is_signed;
        end else if (state == S_PREP) begin
            sq <= a_neg ^ b_neg;
            sr <= a_neg;
        end
    end
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
    assign q_neg = 1'b0;
    assign r_neg = 1'b0;
`endif

    // control FSM with registered busy/done; hi/lo only change on FIX or a zero divisor
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            num         <= '0;
            den         <= '0;
            rem         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            div_hi      <= '0;
            div_lo      <= '0;
        end else if (cancel) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                    busy        <= start;
                    state       <= start ? S_PREP : S_IDLE;
                    if (start) begin
                        num <= dividend;
                        den <= divisor;
                    end
                end
                S_PREP: begin
                    if (den == '0) begin
                        div_lo      <= '1;
                        div_hi      <= num;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_DONE;
                    end else begin
                        num   <= a_neg ? -num : num;
                        den   <= b_neg ? -den : den;
                        rem   <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    num   <= num_nx;
                    rem   <= rem_nx;
                    cnt   <= cnt - 1'b1;
                    state <= (cnt == '0) ? S_FIX : S_RUN;
                end
                S_FIX: begin
                    div_lo <= q_neg ? -num : num;
                    div_hi <= r_neg ? -rem : rem;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/multicycle_divider.md
MULTICYCLE_DIVIDER -- requirements
Module: multicycle_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a divide; driven by has_div_d after the decode-to-execute register.
REQ-005 SHALL have port is_signed, input, 1 bit: 1 selects DIV, 0 selects DIVU.
REQ-006 SHALL have port dividend, input, WIDTH bits: the rs value.
REQ-007 SHALL have port divisor, input, WIDTH bits: the rt value.
REQ-008 SHALL have port cancel, input, 1 bit: pipeline flush; abandons the operation in progress.
REQ-009 SHALL have port busy, output, 1 bit: operation in progress; the hazard unit stalls MFHI/MFLO and a new DIV on it.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking hi/lo valid; feeds has_div_w.
REQ-011 SHALL have port div_hi, output, WIDTH bits: remainder; feeds div_hi_w.
REQ-012 SHALL have port div_lo, output, WIDTH bits: quotient; feeds div_lo_w.
REQ-013 SHALL have port div_by_zero, output, 1 bit: divisor was zero; valid while done=1.

Function
REQ-014 SHALL implement the states IDLE, PREP, RUN, FIX and DONE.
REQ-015 IDLE or DONE with start=1 SHALL capture operands and go to PREP; start SHALL be ignored in PREP, RUN and FIX.
REQ-016 PREP SHALL take absolute values when is_signed=1, and raw values otherwise.
REQ-017 PREP SHALL record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign), then go to RUN with the iteration counter at WIDTH-1.
REQ-018 RUN SHALL perform one restoring shift-subtract step per cycle for exactly WIDTH cycles, then go to FIX.
REQ-019 FIX SHALL two's-complement negate the quotient and the remainder per the recorded signs (signed mode only), load div_lo and div_hi, then go to DONE.
REQ-020 DONE SHALL assert done for exactly one cycle and then go to IDLE unless start=1.
REQ-021 Latency: with start high in cycle 0, done SHALL be high in cycle WIDTH+3 (cycle 35 for WIDTH=32).
REQ-022 busy SHALL be 1 in PREP, RUN and FIX, and 0 in IDLE and DONE.
REQ-023 div_hi and div_lo SHALL hold their values from DONE until the next FIX.
REQ-024 Divisor zero detected in PREP: go directly to DONE with div_lo=all ones, div_hi=dividend as captured, div_by_zero=1; done SHALL be high in cycle 2.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL yield div_lo=0x80000000 and div_hi=0 with no flag.
REQ-026 cancel=1 in any state SHALL force IDLE at the next edge, suppress done, and leave div_hi/div_lo unchanged; cancel SHALL take priority over a simultaneous start.

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, div_by_zero=0, div_hi=0, div_lo=0 and the counter to 0, including mid-operation.
REQ-028 After reset release, start SHALL be honoured on the first rising edge.

Configuration
REQ-029 With macro MULTICYCLE_DIVIDER_SIGNED_EN defined, is_signed SHALL behave per REQ-016 to REQ-019 and REQ-025.
REQ-030 Without MULTICYCLE_DIVIDER_SIGNED_EN, is_signed SHALL be ignored, all divides SHALL be unsigned, and the sign logic SHALL be absent.

Structure
REQ-031 State encodings and the WIDTH default SHALL live in a shared definitions header included by the divider and the hazard unit.
REQ-032 One combinational sub-module, div_step, SHALL implement a single shift-subtract step (partial remainder and quotient bit in, updated values out).

Verification
REQ-033 Unsigned 100/7, start in cycle 0 -> done in cycle 35, div_lo=14, div_hi=2, busy=1 in cycles 1-34.
REQ-034 Signed -7/2 (0xFFFFFFF9, 2) -> div_lo=0xFFFFFFFD, div_hi=0xFFFFFFFF.
REQ-035 Signed 0x80000000/0xFFFFFFFF -> div_lo=0x80000000, div_hi=0; 5/0 -> done in cycle 2, div_lo=0xFFFFFFFF, div_hi=5, div_by_zero=1.
REQ-036 Second start pulsed in cycle 10 of a divide -> ignored, single done in cycle 35; start held in DONE -> back-to-back operation, done again in cycle 35 after that.
REQ-037 cancel in cycle 20 -> IDLE in cycle 21, no done, prior hi/lo retained; reset_n low in cycle 15 -> outputs zero immediately.
